fetch_ctrl: RTL and testbench

// Instruction-fetch front end; writer side of the instruction buffer.
// - Issues word-aligned 32-bit fetch requests to instruction memory and tracks outstanding requests.
// - Delivers each response as pc/rdata/error/ready to the buffer, which reads it out as compressed or full instructions.
// - On redirect: pulses clear/align to the buffer and discards stale responses.
// - If the buffer is stalled, re-fetches any word it could not accept.

---
 rtl/fetch_ctrl.sv | 117 +++++++++++
 tb/tb_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch front end: issues word-aligned fetches, tracks outstanding
// requests and writes each response into the instruction buffer.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_jump,
  input  logic [31:0] fetch_target,
  input  logic        fetch_stall,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        imem_error,
  output logic        buf_clear,
  output logic        buf_align,
  output logic [31:0] buf_pc,
  output logic [31:0] buf_rdata,
  output logic        buf_error,
  output logic        buf_ready
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  // Memory handshake: a request transfers on imem_valid & imem_gnt; responses
  // return in request order, one per imem_ready, with no back-pressure.

  logic [31:0]   r_req_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;

  logic [31:0]   w_req_pc_nxt;
  logic [31:0]   w_rsp_pc_nxt;
  logic [CW-1:0] w_outst_nxt;
  logic [CW-1:0] w_drop_nxt;

  logic          w_valid;
  logic          w_issue;
  logic          w_rsp;
  logic          w_live;
  logic          w_deliver;
  logic          w_replay;
  logic [31:0]   w_target_word;
  logic          w_unused_target_lsb;

  assign w_unused_target_lsb = fetch_target[0];
  assign w_target_word       = {fetch_target[31:2], 2'b00};

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp     = imem_ready & (r_outst != '0);
  assign w_live    = w_rsp & (r_drop == '0);
  assign w_valid   = reset & ~fetch_jump & ~fetch_stall & (r_outst < MAX_OUT_C);
  assign w_issue   = w_valid & imem_gnt;
  assign w_deliver = reset & w_live & ~fetch_stall & ~fetch_jump;
  assign w_replay  = w_live & fetch_stall & ~fetch_jump;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_req_pc <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_outst  <= '0;
      r_drop   <= '0;
    end else begin
      r_req_pc <= w_req_pc_nxt;
      r_rsp_pc <= w_rsp_pc_nxt;
      r_outst  <= w_outst_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  always_comb begin
    w_req_pc_nxt = r_req_pc;
    w_rsp_pc_nxt = r_rsp_pc;
    w_drop_nxt   = r_drop;
    w_outst_nxt  = r_outst + CW'(w_issue) - CW'(w_rsp);

    if (fetch_jump) begin
      // Everything still in flight after this cycle belongs to the old path.
      w_req_pc_nxt = w_target_word;
      w_rsp_pc_nxt = w_target_word;
      w_drop_nxt   = r_outst - CW'(w_rsp);
    end else begin
      if (w_issue) begin
        w_req_pc_nxt = r_req_pc + 32'd4;
      end
      if (w_rsp) begin
        if (r_drop != '0) begin
          w_drop_nxt = r_drop - ONE_C;
        end else if (w_replay) begin
          // Buffer refused this word: rewind and discard the younger requests.
          w_req_pc_nxt = r_rsp_pc;
          w_drop_nxt   = r_outst - ONE_C;
        end else begin
          w_rsp_pc_nxt = r_rsp_pc + 32'd4;
        end
      end
    end
  end

  always_comb begin
    imem_valid = w_valid;
    imem_addr  = reset ? r_req_pc : 32'h0;
    buf_clear  = reset & fetch_jump;
    buf_align  = reset & fetch_jump & fetch_target[1];
    buf_ready  = w_deliver;
    buf_pc     = w_deliver ? r_rsp_pc   : 32'h0;
    buf_rdata  = w_deliver ? imem_rdata : 32'h0;
    buf_error  = w_deliver & imem_error;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: issue, back-pressure, redirect, replay,
// fault delivery and asynchronous reset, with hand-computed expectations.
module tb_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic        fetch_jump;
  logic [31:0] fetch_target;
  logic        fetch_stall;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_error;
  logic        buf_clear;
  logic        buf_align;
  logic [31:0] buf_pc;
  logic [31:0] buf_rdata;
  logic        buf_error;
  logic        buf_ready;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  fetch_ctrl #(.RESET_PC(32'h100), .MAX_OUT(2)) dut (
    .clock(clock), .reset(reset),
    .fetch_jump(fetch_jump), .fetch_target(fetch_target), .fetch_stall(fetch_stall),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .imem_error(imem_error),
    .buf_clear(buf_clear), .buf_align(buf_align), .buf_pc(buf_pc),
    .buf_rdata(buf_rdata), .buf_error(buf_error), .buf_ready(buf_ready)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // driver tasks
  task automatic drive(input logic gnt, input logic rdy, input logic [31:0] rdata,
                       input logic err, input logic stall, input logic jump,
                       input logic [31:0] target);
    imem_gnt     = gnt;
    imem_ready   = rdy;
    imem_rdata   = rdata;
    imem_error   = err;
    fetch_stall  = stall;
    fetch_jump   = jump;
    fetch_target = target;
    @(negedge clock);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_delivery(input string tag, input logic [31:0] rdata);
    logic [31:0] exp_pc;
    exp_pc = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hdead_beef;
    check({tag, "_ready"}, {31'b0, buf_ready}, 32'd1);
    check({tag, "_pc"}, buf_pc, exp_pc);
    check({tag, "_rdata"}, buf_rdata, rdata);
  endtask

  initial begin
    reset = 1'b0;
    imem_gnt = 0; imem_ready = 0; imem_rdata = 0; imem_error = 0;
    fetch_stall = 0; fetch_jump = 0; fetch_target = 0;
    #2;
    check("rst_valid", {31'b0, imem_valid}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_ready", {31'b0, buf_ready}, 32'd0);
    check("rst_clear", {31'b0, buf_clear}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    tick();

    // 1) streaming fetch, response one cycle after grant
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t1_valid0", {31'b0, imem_valid}, 32'd1);
    check("t1_addr0", imem_addr, 32'h100);
    tick();
    drive(1, 1, 32'hA000_0000, 0, 0, 0, 0);
    check("t1_addr1", imem_addr, 32'h104);
    check_delivery("t1_rsp0", 32'hA000_0000);
    tick();
    drive(1, 1, 32'hA000_0001, 0, 0, 0, 0);
    check("t1_addr2", imem_addr, 32'h108);
    check_delivery("t1_rsp1", 32'hA000_0001);
    tick();
    drive(0, 1, 32'hA000_0002, 0, 0, 0, 0);
    check_delivery("t1_rsp2", 32'hA000_0002);
    check("t1_err", {31'b0, buf_error}, 32'd0);
    tick();

    // 2) outstanding limit
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t2_addr0", imem_addr, 32'h10C);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t2_addr1", imem_addr, 32'h110);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t2_full", {31'b0, imem_valid}, 32'd0);
    tick();
    exp_q.push_back(32'h10C);
    drive(1, 1, 32'hB000_0000, 0, 0, 0, 0);
    check("t2_full_rsp", {31'b0, imem_valid}, 32'd0);
    check_delivery("t2_rsp", 32'hB000_0000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t2_reopen", {31'b0, imem_valid}, 32'd1);
    tick();

    // 3) redirect with two outstanding (0x110 and 0x114)
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t3_addr", imem_addr, 32'h114);
    tick();
    drive(1, 0, 0, 0, 0, 1, 32'h2002);
    check("t3_clear", {31'b0, buf_clear}, 32'd1);
    check("t3_align", {31'b0, buf_align}, 32'd1);
    check("t3_novalid", {31'b0, imem_valid}, 32'd0);
    tick();
    drive(1, 1, 32'hDEAD_0000, 0, 0, 0, 0);
    check("t3_newaddr", imem_addr, 32'h2000);
    check("t3_drop0", {31'b0, buf_ready}, 32'd0);
    tick();
    drive(1, 1, 32'hDEAD_0001, 0, 0, 0, 0);
    check("t3_valid", {31'b0, imem_valid}, 32'd1);
    check("t3_drop1", {31'b0, buf_ready}, 32'd0);
    tick();
    exp_q.push_back(32'h2000);
    drive(0, 1, 32'hC000_0000, 0, 0, 0, 0);
    check_delivery("t3_rsp", 32'hC000_0000);
    tick();

    // 4) stall replay: 0x108 refused, 0x10C dropped, 0x108 re-fetched
    drive(0, 0, 0, 0, 0, 1, 32'h108);
    check("t4_align", {31'b0, buf_align}, 32'd0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t4_addr0", imem_addr, 32'h108);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t4_addr1", imem_addr, 32'h10C);
    tick();
    drive(1, 1, 32'hD000_0000, 0, 1, 0, 0);
    check("t4_stall_valid", {31'b0, imem_valid}, 32'd0);
    check("t4_stall_ready", {31'b0, buf_ready}, 32'd0);
    check("t4_stall_pc", buf_pc, 32'h0);
    tick();
    drive(1, 1, 32'hD000_0001, 0, 1, 0, 0);
    check("t4_drop", {31'b0, buf_ready}, 32'd0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t4_refetch_v", {31'b0, imem_valid}, 32'd1);
    check("t4_refetch", imem_addr, 32'h108);
    tick();
    exp_q.push_back(32'h108);
    drive(0, 1, 32'hD000_0002, 0, 0, 0, 0);
    check_delivery("t4_rsp", 32'hD000_0002);
    tick();

    // 5) jump + stall + response in one cycle
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t5_addr", imem_addr, 32'h10C);
    tick();
    drive(1, 1, 32'hE000_0000, 0, 1, 1, 32'h3000);
    check("t5_clear", {31'b0, buf_clear}, 32'd1);
    check("t5_ready", {31'b0, buf_ready}, 32'd0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t5_resume", imem_addr, 32'h3000);
    tick();
    exp_q.push_back(32'h3000);
    drive(0, 1, 32'hE000_0001, 0, 0, 0, 0);
    check_delivery("t5_rsp", 32'hE000_0001);
    tick();

    // 6) fault delivery, stray response, async reset mid-flight
    drive(0, 0, 0, 0, 0, 1, 32'h104);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t6_addr0", imem_addr, 32'h104);
    tick();
    exp_q.push_back(32'h104);
    drive(1, 1, 32'hF000_0000, 1, 0, 0, 0);
    check_delivery("t6_fault", 32'hF000_0000);
    check("t6_err", {31'b0, buf_error}, 32'd1);
    check("t6_next", imem_addr, 32'h108);
    check("t6_next_v", {31'b0, imem_valid}, 32'd1);
    tick();
    exp_q.push_back(32'h108);
    drive(0, 1, 32'hF000_0001, 0, 0, 0, 0);
    check_delivery("t6_after", 32'hF000_0001);
    tick();
    drive(0, 1, 32'hF000_0002, 0, 0, 0, 0);
    check("t6_stray", {31'b0, buf_ready}, 32'd0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t6_addr2", imem_addr, 32'h10C);
    tick();
    imem_gnt = 1; imem_ready = 1; imem_rdata = 32'h1234_5678;
    #2;
    check("t6_pre_rst", {31'b0, buf_ready}, 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", {31'b0, imem_valid}, 32'd0);
    check("t6_rst_ready", {31'b0, buf_ready}, 32'd0);
    check("t6_rst_pc", buf_pc, 32'h0);
    check("t6_rst_addr", imem_addr, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t6_restart", imem_addr, 32'h100);
    tick();
    exp_q.push_back(32'h100);
    drive(0, 1, 32'h5555_AAAA, 0, 0, 0, 0);
    check_delivery("t6_restart_rsp", 32'h5555_AAAA);
    tick();
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
